multi_port_ram: RTL and testbench
=================================

Name: multi_port_ram

Overview:
- Parametrised successor to the team's single-read dual-port RAM.
- One write port with byte enables; RD_PORTS independent read ports.
- Per-byte read-during-write forwarding (new data wins on written bytes); optional output register stage.
- Built-in clear engine zeroes the array after reset or on request; used for register-file, scratchpad and cache-tag storage in the core.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8.
- AW, 12, address width.
- MEM_NUM, 4096, number of words; must be ≤ 2^AW.
- RD_PORTS, 2, number of read ports (1..4).
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, latency 2.
- CLR_ON_RST, 1, 1 = run the clear sweep after reset release.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous active-low reset.
- w_en  input  1  write request.
- w_addr_i  input  AW  write address.
- w_data_i  input  DW  write data.
- w_be_i  input  DW/8  byte enables; bit k covers bits [8k+7:8k].
- r_en_i  input  RD_PORTS  per-port read request.
- r_addr_i  input  RD_PORTS*AW  packed read addresses; port p at [p*AW +: AW].
- r_data_o  output  RD_PORTS*DW  packed read data; port p at [p*DW +: DW].
- r_valid_o  output  RD_PORTS  per-port read-data valid.
- clr_req_i  input  1  clear request pulse.
- init_done_o  output  1  1 when the array is usable (state READY).

Behaviour:
- Reset (rst=0, asynchronous):
  - r_data_o = 0, r_valid_o = 0, clear counter = 0, pipeline registers = 0.
  - State = CLEAR if CLR_ON_RST=1, else READY.
  - init_done_o = (state == READY); it is a decode of the state register, so its reset value is !CLR_ON_RST.
  - Array contents are not touched by reset.
- FSM states:
  - CLEAR: each cycle, write 0 to address cnt, then cnt++. When cnt == MEM_NUM-1 is written, go to READY. Duration is exactly MEM_NUM cycles.
  - READY: normal operation. clr_req_i=1 → CLEAR with cnt=0; the user write in that same cycle is still performed.
- CLEAR rules:
  - w_en and r_en_i are ignored; r_valid_o stays 0.
  - clr_req_i during CLEAR does not restart the sweep.
  - Reset during CLEAR aborts the sweep; it restarts from 0 per CLR_ON_RST.
- Write (READY):
  - If w_en=1 and w_addr_i < MEM_NUM, each byte with w_be_i[k]=1 is updated at the clock edge; other bytes are unchanged.
  - Address ≥ MEM_NUM: the write is dropped.
  - w_be_i = 0: no change.
- Read (READY), per port p, independent of the other ports:
  - r_en_i[p]=1 samples the array at r_addr_i[p].
  - OUT_REG=0: data on r_data_o[p] and r_valid_o[p]=1 in the next cycle.
  - OUT_REG=1: data and valid one cycle later (latency 2).
  - r_valid_o[p] is 1 for exactly one cycle per accepted request; back-to-back requests give back-to-back valids (throughput 1 per port per cycle).
  - r_data_o[p] holds its last value while r_valid_o[p]=0.
  - Address ≥ MEM_NUM: returns 0 with valid=1.
- Read-during-write forwarding:
  - Applies when w_en, r_en_i[p] and w_addr_i == r_addr_i[p] are all true in the same cycle.
  - Returned word: bytes with w_be_i=1 come from w_data_i; other bytes are the pre-write array contents.
  - Multiple ports hitting the same address all get the forwarded word.
  - With OUT_REG=1, a write landing during the output-register cycle is NOT forwarded; the registered value stands.
- Reads of different addresses on different ports in the same cycle never interfere.
- Memory inference: the array is a plain reg array without reset, so tools map it to block RAM; forwarding and merge logic sit outside the array.

Test Plan:
- Reset then clock with CLR_ON_RST=1, MEM_NUM=16 → init_done_o=0 for exactly 16 cycles, then 1; read all 16 addresses → 0.
- READY: write 0x11223344 to addr 5 (be=4'hF), then write 0xAABBCCDD to addr 5 with be=4'b0101, read port0 addr 5 next cycle → r_data_o[31:0]=0x11BB33DD, r_valid_o[0]=1 one cycle after the request (OUT_REG=0).
- Same-cycle collision: addr 7 holds 0x00000000; in one cycle w_en, addr 7, data 0xDEADBEEF, be=4'b1100, and both ports read addr 7 → both ports return 0xDEAD0000 the next cycle.
- OUT_REG=1: read addr 3 (holding 0x5) → valid exactly 2 cycles later with 0x5; a write of 0x9 to addr 3 in cycle +1 → returned data still 0x5.
- clr_req_i pulse in READY, followed by reads and writes during CLEAR → writes ignored, r_valid_o stays 0; after MEM_NUM cycles init_done_o=1 and prior data reads 0.
- Assert rst mid-CLEAR (cnt=8) → outputs zero immediately; after release the sweep restarts at 0 and takes the full MEM_NUM cycles. Read address ≥ MEM_NUM → 0 with valid=1.

Source files
------------

// File: rtl/multi_port_ram.sv
// rtl/multi_port_ram.sv - byte-enabled RAM, one write port, RD_PORTS read ports, forwarding and clear engine
// The array is reset-free; forwarding is merged after the registered array read.
module multi_port_ram #(
  parameter int DW         = 32,
  parameter int AW         = 12,
  parameter int MEM_NUM    = 4096,
  parameter int RD_PORTS   = 2,
  parameter int OUT_REG    = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_en,
  input  logic [AW-1:0]          w_addr_i,
  input  logic [DW-1:0]          w_data_i,
  input  logic [DW/8-1:0]        w_be_i,
  input  logic [RD_PORTS-1:0]    r_en_i,
  input  logic [RD_PORTS*AW-1:0] r_addr_i,
  output logic [RD_PORTS*DW-1:0] r_data_o,
  output logic [RD_PORTS-1:0]    r_valid_o,
  input  logic                   clr_req_i,
  output logic                   init_done_o
);

  localparam int              NB      = DW / 8;
  localparam int              IW      = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;
  localparam logic [AW:0]     MEM_LIM = (AW+1)'(MEM_NUM);
  localparam logic [AW-1:0]   LAST    = AW'(MEM_NUM - 1);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  logic          w_ready;
  logic          w_wr_ok;

  logic [DW-1:0] r_mem [MEM_NUM];

  assign w_ready     = (r_state == S_READY);
  assign init_done_o = w_ready;
  assign w_wr_ok     = w_ready && w_en && ({1'b0, w_addr_i} < MEM_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= (CLR_ON_RST != 0) ? S_CLEAR : S_READY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_CLEAR: begin
        if (r_cnt == LAST) begin
          w_state_nxt = S_READY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_READY: begin
        if (clr_req_i) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_READY;
      end
    endcase
  end

  // Sweep writes share the single write port; user writes are blocked while clearing.
  always_ff @(posedge clk) begin
    if (!w_ready && rst) begin
      r_mem[r_cnt[IW-1:0]] <= '0;
    end else if (w_wr_ok) begin
      for (int k = 0; k < NB; k++) begin
        if (w_be_i[k]) r_mem[w_addr_i[IW-1:0]][8*k +: 8] <= w_data_i[8*k +: 8];
      end
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_in;
    logic          w_acc;
    logic [NB-1:0] w_hit;
    logic [DW-1:0] w_merged;
    logic [DW-1:0] r_raw;
    logic [DW-1:0] r_fwd_data;
    logic [NB-1:0] r_fwd_mask;
    logic          r_v1;

    assign w_ra  = r_addr_i[p*AW +: AW];
    assign w_in  = ({1'b0, w_ra} < MEM_LIM);
    assign w_acc = w_ready && r_en_i[p];

    for (genvar k = 0; k < NB; k++) begin : g_hit
      assign w_hit[k] = w_en && w_be_i[k] && (w_addr_i == w_ra);
    end

    // Registers only load on an accepted read, so the merged word holds between requests.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_v1       <= 1'b0;
        r_raw      <= '0;
        r_fwd_data <= '0;
        r_fwd_mask <= '0;
      end else begin
        r_v1 <= w_acc;
        if (w_acc) begin
          r_raw      <= w_in ? r_mem[w_ra[IW-1:0]] : '0;
          r_fwd_mask <= w_in ? w_hit : '0;
          r_fwd_data <= w_data_i;
        end
      end
    end

    for (genvar k = 0; k < NB; k++) begin : g_merge
      assign w_merged[8*k +: 8] = r_fwd_mask[k] ? r_fwd_data[8*k +: 8] : r_raw[8*k +: 8];
    end

    if (OUT_REG != 0) begin : g_oreg
      logic [DW-1:0] r_d2;
      logic          r_v2;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_d2 <= '0;
          r_v2 <= 1'b0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) r_d2 <= w_merged;
        end
      end

      assign r_data_o[p*DW +: DW] = r_d2;
      assign r_valid_o[p]         = r_v2;
    end else begin : g_noreg
      assign r_data_o[p*DW +: DW] = w_merged;
      assign r_valid_o[p]         = r_v1;
    end
  end

endmodule

// File: tb/tb_multi_port_ram.sv
// tb/tb_multi_port_ram.sv - randomized and directed checks of multi_port_ram, OUT_REG=0 and OUT_REG=1 side by side
module tb_multi_port_ram;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int MN = 16;
  localparam int NP = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            w_en;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic [DW/8-1:0] w_be;
  logic [NP-1:0]   r_en;
  logic [NP*AW-1:0] r_addr;
  logic            clr_req;

  logic [NP*DW-1:0] rd0, rd1;
  logic [NP-1:0]    rv0, rv1;
  logic             done0, done1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] mm [MN];
  int            clear_left;
  logic [DW-1:0] e0d [NP];
  logic [DW-1:0] s1d [NP];
  logic [DW-1:0] e1d [NP];
  logic          e0v [NP];
  logic          s1v [NP];
  logic          e1v [NP];

  always #5 clk = ~clk;

  multi_port_ram #(.DW(DW), .AW(AW), .MEM_NUM(MN), .RD_PORTS(NP), .OUT_REG(0), .CLR_ON_RST(1)) dut0 (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr_i(w_addr), .w_data_i(w_data), .w_be_i(w_be),
    .r_en_i(r_en), .r_addr_i(r_addr), .r_data_o(rd0), .r_valid_o(rv0),
    .clr_req_i(clr_req), .init_done_o(done0)
  );

  multi_port_ram #(.DW(DW), .AW(AW), .MEM_NUM(MN), .RD_PORTS(NP), .OUT_REG(1), .CLR_ON_RST(1)) dut1 (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr_i(w_addr), .w_data_i(w_data), .w_be_i(w_be),
    .r_en_i(r_en), .r_addr_i(r_addr), .r_data_o(rd1), .r_valid_o(rv1),
    .clr_req_i(clr_req), .init_done_o(done1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("done0", done0, clear_left == 0);
    check("done1", done1, clear_left == 0);
    for (int p = 0; p < NP; p++) begin
      check("lat1_valid", rv0[p], e0v[p]);
      check("lat1_data", rd0[p*DW +: DW], e0d[p]);
      check("lat2_valid", rv1[p], e1v[p]);
      check("lat2_data", rd1[p*DW +: DW], e1d[p]);
    end
  endtask

  // Model one clock edge from the current inputs, then compare both instances.
  task automatic step();
    logic [DW-1:0] rdat [NP];
    logic          rval [NP];
    logic [AW-1:0] a;
    for (int p = 0; p < NP; p++) begin
      rval[p] = 1'b0;
      rdat[p] = '0;
      if (clear_left == 0 && r_en[p]) begin
        rval[p] = 1'b1;
        a = r_addr[p*AW +: AW];
        if (a < MN) begin
          rdat[p] = mm[a[3:0]];
          if (w_en && w_addr == a)
            for (int k = 0; k < DW/8; k++)
              if (w_be[k]) rdat[p][8*k +: 8] = w_data[8*k +: 8];
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      e1v[p] = s1v[p];
      if (s1v[p]) e1d[p] = s1d[p];
      s1v[p] = rval[p];
      if (rval[p]) s1d[p] = rdat[p];
      e0v[p] = rval[p];
      if (rval[p]) e0d[p] = rdat[p];
    end
    if (clear_left == 0) begin
      if (w_en && w_addr < MN)
        for (int k = 0; k < DW/8; k++)
          if (w_be[k]) mm[w_addr[3:0]][8*k +: 8] = w_data[8*k +: 8];
      if (clr_req) begin
        clear_left = MN;
        for (int i = 0; i < MN; i++) mm[i] = '0;
      end
    end else begin
      clear_left--;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [3:0] be, input logic [1:0] ren,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic clr);
    w_en    = we;
    w_addr  = wa;
    w_data  = wd;
    w_be    = be;
    r_en    = ren;
    r_addr  = {a1, a0};
    clr_req = clr;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 2'b00, '0, '0, 1'b0);
  endtask

  // Asynchronous reset: outputs must drop before any clock edge arrives.
  task automatic do_reset();
    rst = 1'b0;
    #2;
    clear_left = MN;
    for (int i = 0; i < MN; i++) mm[i] = '0;
    for (int p = 0; p < NP; p++) begin
      e0v[p] = 1'b0; s1v[p] = 1'b0; e1v[p] = 1'b0;
      e0d[p] = '0;   s1d[p] = '0;   e1d[p] = '0;
    end
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; w_en = 1'b0; w_addr = '0; w_data = '0; w_be = '0;
    r_en = '0; r_addr = '0; clr_req = 1'b0;
    #1;
    do_reset();
    idle(MN);
    for (int i = 0; i < MN; i++)
      drive(1'b0, '0, '0, '0, 2'b11, AW'(i), AW'(MN - 1 - i), 1'b0);
    idle(2);

    drive(1'b1, 5'd5, 32'h11223344, 4'hF, 2'b00, '0, '0, 1'b0);
    drive(1'b1, 5'd5, 32'hAABBCCDD, 4'b0101, 2'b00, '0, '0, 1'b0);
    drive(1'b0, '0, '0, '0, 2'b01, 5'd5, '0, 1'b0);
    idle(2);

    drive(1'b1, 5'd7, 32'hDEADBEEF, 4'b1100, 2'b11, 5'd7, 5'd7, 1'b0);
    idle(2);

    drive(1'b1, 5'd3, 32'h5, 4'hF, 2'b00, '0, '0, 1'b0);
    drive(1'b0, '0, '0, '0, 2'b01, 5'd3, '0, 1'b0);
    drive(1'b1, 5'd3, 32'h9, 4'hF, 2'b00, '0, '0, 1'b0);
    idle(3);

    drive(1'b1, 5'd9, 32'h12345678, 4'hF, 2'b11, 5'd5, 5'd9, 1'b1);
    for (int i = 0; i < MN; i++)
      drive(1'b1, AW'(i), 32'hFFFF0000 | i, 4'hF, 2'b11, AW'(i), 5'd5, 1'b0);
    drive(1'b0, '0, '0, '0, 2'b11, 5'd5, 5'd3, 1'b0);
    idle(2);

    drive(1'b0, '0, '0, '0, 2'b00, '0, '0, 1'b1);
    idle(8);
    do_reset();
    idle(MN);
    drive(1'b0, '0, '0, '0, 2'b11, 5'd20, 5'd31, 1'b0);
    idle(2);

    for (int i = 0; i < 2000; i++)
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 19)), $urandom, 4'($urandom),
            2'($urandom), AW'($urandom_range(0, 19)), AW'($urandom_range(0, 19)),
            ($urandom_range(0, 199) == 0));
    idle(MN + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
